// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-locking arbiter that lets N requesters share one FIFO write port.
// Define FIFO_ARB_TAG_EN to prepend the owner index to p_write_data.
module fifo_write_arbiter #(
    parameter int unsigned BITS      = 32,
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned IDW      = $clog2(N),
`ifdef FIFO_ARB_TAG_EN
    localparam int unsigned OW       = BITS + IDW
`else
    localparam int unsigned OW       = BITS
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [N*BITS-1:0] req_data,
    input  logic [N-1:0]      req_last,
    output logic [N-1:0]      req_ready,
    output logic              p_write_en,
    output logic [OW-1:0]     p_write_data,
    input  logic              p_write_full,
    output logic [N-1:0]      grant,
    output logic              busy
);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IDW-1:0]  cand, pick_idx;
    logic            pick_found;
    logic            locked;
    logic            xfer;
    logic [BITS-1:0] owner_data;

    // Outputs are forced quiet while rst is asserted, even before the first reset edge.
    assign locked = !rst && (state_q == StLock);
    assign xfer   = locked && req_valid[owner_q] && !p_write_full;

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N; i++) begin
            if (owner_q == IDW'(i)) begin
                owner_data = req_data[i*BITS +: BITS];
            end
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = IDW'((32'(rr_ptr_q) + 32'(i)) % N);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StLock;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            StLock: begin
                if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                    if (req_last[owner_q] || (cnt_d == 8'(MAX_BURST))) begin
                        state_d  = StIdle;
                        rr_ptr_d = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = locked;
        grant        = '0;
        req_ready    = '0;
        p_write_en   = xfer;
        p_write_data = '0;
        if (locked) begin
            grant[owner_q] = 1'b1;
        end
        if (xfer) begin
            req_ready[owner_q] = 1'b1;
`ifdef FIFO_ARB_TAG_EN
            p_write_data = {owner_q, owner_data};
`else
            p_write_data = owner_data;
`endif
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 32: width of each requester data word and FIFO entry payload.
REQ-002 SHALL have parameter N, default 4: number of requesters, legal range 2..8.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant, legal range 1..255.
REQ-004 SHALL have localparam IDW = $clog2(N): requester index width.
REQ-005 SHALL have port clk  input  1: single clock, the FIFO write-domain clock.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  N: per-requester beat valid.
REQ-008 SHALL have port req_data  input  N*BITS: packed beats, requester i at bits [i*BITS +: BITS].
REQ-009 SHALL have port req_last  input  N: per-requester last beat of packet.
REQ-010 SHALL have port req_ready  output  N: per-requester beat accepted this cycle.
REQ-011 SHALL have port p_write_en  output  1: FIFO write request.
REQ-012 SHALL have port p_write_data  output  BITS (BITS+IDW with macro): FIFO write data.
REQ-013 SHALL have port p_write_full  input  1: FIFO full flag.
REQ-014 SHALL have port grant  output  N: one-hot current owner, all zero when none.
REQ-015 SHALL have port busy  output  1: high while in state LOCK.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and LOCK, plus a round-robin pointer rr_ptr (IDW bits) and a beat counter (8 bits).
REQ-017 In IDLE with any req_valid high, SHALL pick the first valid requester searching from rr_ptr upward modulo N, register it as owner, and enter LOCK next cycle; no beat transfers in the IDLE cycle (1-cycle arbitration latency).
REQ-018 In IDLE with no req_valid, SHALL remain in IDLE and hold grant at zero.
REQ-019 In LOCK, a beat SHALL transfer exactly when req_valid[owner]=1 and p_write_full=0; that cycle p_write_en=1, req_ready[owner]=1, and p_write_data=req_data[owner] (combinational, zero latency).
REQ-020 p_write_en SHALL never be high while p_write_full=1, and req_ready SHALL be at most one-hot and only for the owner.
REQ-021 When p_write_en=0, p_write_data SHALL be driven to all zeros.
REQ-022 The beat counter SHALL clear on entry to LOCK and increment by 1 per transferred beat.
REQ-023 LOCK SHALL be released (next state IDLE, rr_ptr = owner+1 modulo N) on a transferred beat with req_last[owner]=1 or on the transfer that makes the counter equal MAX_BURST, whichever occurs first.
REQ-024 In LOCK with req_valid[owner]=0 or p_write_full=1, SHALL hold owner, counter and state; no timeout.
REQ-025 Requests from non-owners SHALL be ignored while in LOCK; their req_ready stays 0.

Reset
REQ-026 On rst=1 at a clk edge, SHALL enter IDLE, set rr_ptr=0, beat counter=0, owner cleared, including mid-packet; the partially sent packet is not resumed.
REQ-027 While in reset and on the first cycle after, p_write_en, req_ready, grant, busy and p_write_data SHALL all be 0.

Configuration
REQ-028 Macro FIFO_ARB_TAG_EN: when defined, p_write_data SHALL be BITS+IDW wide with bits [BITS+IDW-1:BITS] holding the owner index and [BITS-1:0] the payload (all zeros when p_write_en=0).
REQ-029 Without FIFO_ARB_TAG_EN, p_write_data SHALL be BITS wide carrying payload only.

Verification
REQ-030 Reset: hold rst=1 for 3 cycles with all req_valid=1 -> p_write_en=0, grant=0, busy=0, req_ready=0 throughout and in the first cycle after release.
REQ-031 Single packet: req 2 sends 3 beats 0xA0,0xA1,0xA2 with last on 0xA2, full=0 -> grant=0b0100 after 1 cycle, 3 consecutive writes in order, then IDLE with rr_ptr=3.
REQ-032 Round-robin: all 4 requesters valid with 1-beat packets (last=1) -> grant order 0,1,2,3,0, each write separated by one IDLE cycle.
REQ-033 Burst cap: MAX_BURST=4, req 1 sends 6 beats with last on the 6th -> release after beat 4, req 3 (also valid) granted next, req 1 later resumes with beats 5,6.
REQ-034 Full backpressure: full=1 for 5 cycles mid-packet -> p_write_en=0 and req_ready=0 for those cycles, no beat lost or duplicated, counter unchanged.
REQ-035 Reset mid-packet plus tag: with FIFO_ARB_TAG_EN, req 3 writes 2 of 4 beats then rst pulses -> tag bits read 3 on both written beats, then IDLE, rr_ptr=0, req 0 wins next arbitration.
